// File: rtl/gpio_in_debounce.sv
// Board-input conditioning: per-channel synchroniser followed by a consecutive-cycle debouncer.
// Define DEBOUNCE_EDGE_DET_EN to drive rise_o/fall_o; otherwise they are tied low.
module gpio_in_debounce #(
  parameter int unsigned     N_IN            = 8,
  parameter int unsigned     SYNC_STAGES     = 2,
  parameter int unsigned     DEBOUNCE_CYCLES = 250000,
  parameter logic [N_IN-1:0] RESET_VAL       = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] raw_i,
  output logic [N_IN-1:0] db_o,
  output logic            changed_o,
  output logic [N_IN-1:0] rise_o,
  output logic [N_IN-1:0] fall_o
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
  logic [N_IN-1:0]                  sync_val;
  logic [N_IN-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_IN-1:0]                  db_q, db_d;
  logic                             changed_q;

  assign sync_val = sync_q[SYNC_STAGES-1];

  // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // A mismatch must persist for DEBOUNCE_CYCLES samples; any match restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sync_val[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = sync_val[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q      <= RESET_VAL;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      db_q      <= db_d;
      cnt_q     <= cnt_d;
      changed_q <= |(db_d ^ db_q);
    end
  end

  assign db_o      = db_q;
  assign changed_o = changed_q;

`ifdef DEBOUNCE_EDGE_DET_EN
  logic [N_IN-1:0] rise_q, fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= db_d & ~db_q;
      fall_q <= ~db_d & db_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule
